picosoc_iomem_fabric: RTL and testbench

//  Registered N-slave decoder for the SoC iomem region.
//  - Sits between the CPU native memory bus and NUM_SLAVES external peripherals.
//  - Replaces the single iomem_valid/iomem_ready pass-through with per-slave selects.
//  - Provides a bounded-latency handshake with a bus timeout, so a dead slave cannot hang the CPU.

---
 rtl/picosoc_iomem_fabric.sv | 150 +++++++++++++++
 tb/tb_picosoc_iomem_fabric.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picosoc_iomem_fabric.sv
// picosoc_iomem_fabric
// Registered N-slave decoder for the SoC iomem region, with a bounded-latency
// handshake. A transaction walks IDLE -> ACCESS -> DONE; a slave that never
// answers is cut off after TIMEOUT_CYCLES access cycles and the CPU gets
// TIMEOUT_RDATA back.
// Optional build macro: PICOSOC_IOMEM_ERR_EN adds err_irq/err_addr, which
// report timed-out accesses.
module picosoc_iomem_fabric #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [31:0] ADDR_BASE      = 32'h0300_0000,
  parameter int          SLAVE_SHIFT    = 16,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_valid,
  input  logic [31:0]                mem_addr,
  input  logic [31:0]                mem_wdata,
  input  logic [3:0]                 mem_wstrb,
  output logic                       mem_ready,
  output logic [31:0]                mem_rdata,
  output logic [NUM_SLAVES-1:0]      s_valid,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata
`ifdef PICOSOC_IOMEM_ERR_EN
  ,
  output logic                       err_irq,
  output logic [31:0]                err_addr
`endif
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Region end is computed in 33 bits so a top window ending at 2^32 works.
  localparam logic [32:0] REGION_END = {1'b0, ADDR_BASE} + (33'(NUM_SLAVES) << SLAVE_SHIFT);
  localparam logic [31:0] WIN_MASK   = 32'((33'd1 << SLAVE_SHIFT) - 33'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] sel_idx;
  logic [CNT_W-1:0] cnt;

  logic             hit;
  logic [31:0]      offset;
  logic [IDX_W-1:0] req_idx;
  logic             sel_ready;
  logic [31:0]      sel_rdata;
  logic             timeout_hit;

`ifdef PICOSOC_IOMEM_ERR_EN
  logic [31:0]      req_addr;
`endif

  assign offset      = mem_addr - ADDR_BASE;
  assign hit         = ({1'b0, mem_addr} >= {1'b0, ADDR_BASE}) && ({1'b0, mem_addr} < REGION_END);
  assign req_idx     = IDX_W'(offset >> SLAVE_SHIFT);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  // Pick the ready bit and read data of the latched slave; other slaves are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  // Transaction FSM with all bus outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel_idx   <= '0;
      cnt       <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      s_valid   <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
`ifdef PICOSOC_IOMEM_ERR_EN
      req_addr  <= '0;
      err_irq   <= 1'b0;
      err_addr  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          if (mem_valid && hit) begin
            sel_idx  <= req_idx;
            s_valid  <= NUM_SLAVES'(1) << req_idx;
            s_addr   <= offset & WIN_MASK;
            s_wdata  <= mem_wdata;
            s_wstrb  <= mem_wstrb;
`ifdef PICOSOC_IOMEM_ERR_EN
            req_addr <= mem_addr;
`endif
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // Saturate rather than wrap; only matters when timeout is disabled.
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (sel_ready) begin
            mem_rdata <= sel_rdata;
            s_valid   <= '0;
            mem_ready <= 1'b1;
            state     <= DONE;
          end else if (timeout_hit) begin
            mem_rdata <= TIMEOUT_RDATA;
            s_valid   <= '0;
            mem_ready <= 1'b1;
`ifdef PICOSOC_IOMEM_ERR_EN
            err_irq   <= 1'b1;
            err_addr  <= req_addr;
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          mem_ready <= 1'b0;
          cnt       <= '0;
`ifdef PICOSOC_IOMEM_ERR_EN
          err_irq   <= 1'b0;
`endif
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picosoc_iomem_fabric.sv
// Testbench for picosoc_iomem_fabric: table-driven directed vectors, a few
// hand-written corner sequences and randomized transactions checked against
// a behavioural address-map/latency model.
module tb_picosoc_iomem_fabric;

  localparam int          NS   = 4;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam logic [31:0] TORD = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          k;      // cycles after s_valid before s_ready; -1 = never
    logic [31:0] sdata;  // data driven by the selected slave
    bit          hit;
    int          idx;
    logic [31:0] off;
    int          lat;    // edges after the accept edge until mem_ready
    logic [31:0] rdata;
    bit          to;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            mem_valid;
  logic [31:0]     mem_addr, mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ready;
  logic [31:0]     mem_rdata;
  logic [NS-1:0]   s_valid;
  logic [31:0]     s_addr, s_wdata;
  logic [3:0]      s_wstrb;
  logic [NS-1:0]   s_ready;
  logic [32*NS-1:0] s_rdata;

  // Second instance whose top window ends exactly at 2^32.
  logic            m2_valid;
  logic [31:0]     m2_addr, m2_wdata;
  logic [3:0]      m2_wstrb;
  logic            m2_ready;
  logic [31:0]     m2_rdata;
  logic [NS-1:0]   s2_valid;
  logic [31:0]     s2_addr, s2_wdata;
  logic [3:0]      s2_wstrb;
  logic [NS-1:0]   s2_ready;
  logic [32*NS-1:0] s2_rdata;

`ifdef PICOSOC_IOMEM_ERR_EN
  logic            err_irq, err2_irq;
  logic [31:0]     err_addr, err2_addr;
`endif

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  picosoc_iomem_fabric #(
    .NUM_SLAVES(NS), .ADDR_BASE(BASE), .SLAVE_SHIFT(16),
    .TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(TORD)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata)
`ifdef PICOSOC_IOMEM_ERR_EN
    , .err_irq(err_irq), .err_addr(err_addr)
`endif
  );

  picosoc_iomem_fabric #(
    .NUM_SLAVES(NS), .ADDR_BASE(32'hFFFC_0000), .SLAVE_SHIFT(16),
    .TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(TORD)
  ) dut2 (
    .clk(clk), .reset(reset),
    .mem_valid(m2_valid), .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_wstrb(m2_wstrb),
    .mem_ready(m2_ready), .mem_rdata(m2_rdata),
    .s_valid(s2_valid), .s_addr(s2_addr), .s_wdata(s2_wdata), .s_wstrb(s2_wstrb),
    .s_ready(s2_ready), .s_rdata(s2_rdata)
`ifdef PICOSOC_IOMEM_ERR_EN
    , .err_irq(err2_irq), .err_addr(err2_addr)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: address map and response timing from plain arithmetic.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] wd,
                                 input logic [3:0] ws, input int k, input logic [31:0] sd);
    vec_t v;
    longint ua, base, win;
    ua   = longint'({32'd0, a});
    base = longint'({32'd0, BASE});
    win  = longint'(1) << 16;
    v.addr  = a;
    v.wdata = wd;
    v.wstrb = ws;
    v.k     = k;
    v.sdata = sd;
    v.hit   = (ua >= base) && (ua < base + NS * win);
    v.idx   = v.hit ? int'((ua - base) / win) : 0;
    v.off   = v.hit ? 32'((ua - base) % win) : 32'd0;
    if (k >= 0 && k < TO) begin
      v.lat = k + 1; v.rdata = sd; v.to = 1'b0;
    end else begin
      v.lat = TO; v.rdata = TORD; v.to = 1'b1;
    end
    return v;
  endfunction

  // Runs one CPU request; starts and ends 1 time unit after a rising edge.
  task automatic run_txn(input vec_t v, input bit drop_early, input string tag);
    int j, hold_bad, seen_sv, seen_rdy;
    bit done;
    logic [NS-1:0] exp_sv;
    mem_valid = 1'b1;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    mem_wstrb = v.wstrb;
    s_ready   = '0;
    for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = $urandom;
    if (v.hit) s_rdata[32*v.idx +: 32] = v.sdata;
    @(posedge clk); #1;
    if (!v.hit) begin
      seen_sv = 0; seen_rdy = 0;
      for (int c = 0; c < TO + 4; c++) begin
        if (s_valid != '0) seen_sv++;
        if (mem_ready) seen_rdy++;
        s_ready = NS'($urandom);
        @(posedge clk); #1;
      end
      chk($sformatf("%s miss_s_valid", tag), seen_sv, 0);
      chk($sformatf("%s miss_mem_ready", tag), seen_rdy, 0);
      mem_valid = 1'b0;
      s_ready = '0;
      return;
    end
    exp_sv = NS'(1) << v.idx;
    chk($sformatf("%s s_valid", tag), s_valid, exp_sv);
    chk($sformatf("%s s_addr", tag), s_addr, v.off);
    chk($sformatf("%s s_wdata", tag), s_wdata, v.wdata);
    chk($sformatf("%s s_wstrb", tag), s_wstrb, v.wstrb);
    j = 0; done = 1'b0; hold_bad = 0;
    while (!done && j <= TO + 4) begin
      if (mem_ready) begin
        done = 1'b1;
      end else begin
        if (s_valid !== exp_sv || s_addr !== v.off || s_wdata !== v.wdata || s_wstrb !== v.wstrb)
          hold_bad++;
        s_ready = NS'($urandom) & ~exp_sv;
        if (j == v.k) s_ready = s_ready | exp_sv;
        if (drop_early) mem_valid = 1'b0;
        @(posedge clk); #1;
        j++;
      end
    end
    chk($sformatf("%s hold_stable", tag), hold_bad, 0);
    if (!done) begin
      chk($sformatf("%s mem_ready_seen", tag), 0, 1);
      mem_valid = 1'b0;
      s_ready = '0;
      return;
    end
    chk($sformatf("%s latency", tag), j, v.lat);
    chk($sformatf("%s mem_rdata", tag), mem_rdata, v.rdata);
    chk($sformatf("%s s_valid_cleared", tag), s_valid, 0);
`ifdef PICOSOC_IOMEM_ERR_EN
    chk($sformatf("%s err_irq", tag), err_irq, v.to);
    if (v.to) chk($sformatf("%s err_addr", tag), err_addr, v.addr);
`endif
    mem_valid = 1'b0;
    s_ready = '0;
    @(posedge clk); #1;
    chk($sformatf("%s single_pulse", tag), mem_ready, 0);
`ifdef PICOSOC_IOMEM_ERR_EN
    chk($sformatf("%s err_irq_pulse", tag), err_irq, 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    vec_t v;
    int cnt_bad;
    logic [31:0] a;
    int k;

    // addr, wdata, wstrb, k, sdata, hit, idx, off, lat, rdata, to
    tbl[0] = '{32'h0301_0010, 32'h0,         4'h0, 2,  32'h1234_5678, 1'b1, 1, 32'h10,   3,  32'h1234_5678, 1'b0};
    tbl[1] = '{32'h0300_0004, 32'hA5A5_0000, 4'hC, 0,  32'hDEAD_0000, 1'b1, 0, 32'h4,    1,  32'hDEAD_0000, 1'b0};
    tbl[2] = '{32'h0304_0000, 32'h0,         4'h0, 0,  32'h0,         1'b0, 0, 32'h0,    0,  32'h0,         1'b0};
    tbl[3] = '{32'h0200_0000, 32'h0,         4'h0, 0,  32'h0,         1'b0, 0, 32'h0,    0,  32'h0,         1'b0};
    tbl[4] = '{32'h0302_0100, 32'h0,         4'h0, -1, 32'h5555_AAAA, 1'b1, 2, 32'h100,  16, 32'hFFFF_FFFF, 1'b1};
    tbl[5] = '{32'h0301_FFFC, 32'h0,         4'h0, 15, 32'hCAFE_F00D, 1'b1, 1, 32'hFFFC, 16, 32'hCAFE_F00D, 1'b0};
    tbl[6] = '{32'h0303_FFFF, 32'h0,         4'h0, 1,  32'h0BAD_BEEF, 1'b1, 3, 32'hFFFF, 2,  32'h0BAD_BEEF, 1'b0};
    tbl[7] = '{32'h02FF_FFFF, 32'h0,         4'h0, 0,  32'h0,         1'b0, 0, 32'h0,    0,  32'h0,         1'b0};
    tbl[8] = '{32'h0303_0000, 32'h1111_2222, 4'h1, 14, 32'h7777_8888, 1'b1, 3, 32'h0,    15, 32'h7777_8888, 1'b0};

    reset = 1'b1;
    mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0; s_ready = 0; s_rdata = 0;
    m2_valid = 0; m2_addr = 0; m2_wdata = 0; m2_wstrb = 0; s2_ready = 0; s2_rdata = 0;
    #3;
    chk("rst mem_ready", mem_ready, 0);
    chk("rst mem_rdata", mem_rdata, 0);
    chk("rst s_valid", s_valid, 0);
    chk("rst s_addr", s_addr, 0);
    chk("rst s_wdata", s_wdata, 0);
    chk("rst s_wstrb", s_wstrb, 0);
`ifdef PICOSOC_IOMEM_ERR_EN
    chk("rst err_irq", err_irq, 0);
    chk("rst err_addr", err_addr, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 9; i++) run_txn(tbl[i], (i == 4), $sformatf("tbl%0d", i));

    // Reset asserted mid-ACCESS clears s_valid without waiting for a clock.
    mem_valid = 1'b1; mem_addr = 32'h0301_0000; mem_wstrb = 4'h0; s_ready = '0;
    @(posedge clk); #1;
    chk("rstacc s_valid_before", s_valid, 4'b0010);
    #2 reset = 1'b1;
    #1;
    chk("rstacc s_valid_async", s_valid, 0);
    chk("rstacc mem_ready", mem_ready, 0);
    mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cnt_bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (mem_ready || s_valid != '0) cnt_bad++;
      @(posedge clk); #1;
    end
    chk("rstacc quiet_after", cnt_bad, 0);
    run_txn(tbl[0], 1'b0, "after_rst");

    // Top window of the second instance ends at 2^32.
    m2_valid = 1'b1; m2_addr = 32'hFFFF_FFF0; m2_wstrb = 4'h0;
    s2_rdata = {32'h600D_F00D, 96'h0};
    @(posedge clk); #1;
    chk("top s_valid", s2_valid, 4'b1000);
    chk("top s_addr", s2_addr, 32'hFFF0);
    s2_ready = 4'b1000;
    @(posedge clk); #1;
    chk("top mem_ready", m2_ready, 1);
    chk("top mem_rdata", m2_rdata, 32'h600D_F00D);
    m2_valid = 1'b0; s2_ready = '0;
    @(posedge clk); #1;
    m2_valid = 1'b1; m2_addr = 32'hFFFB_FFFF;
    cnt_bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (m2_ready || s2_valid != '0) cnt_bad++;
    end
    chk("top below_base_miss", cnt_bad, 0);
    m2_valid = 1'b0;

    // Randomized transactions against the model.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: a = $urandom;
        1: a = BASE + 32'($urandom_range(0, NS * 65536 - 1));
        2: a = BASE - 32'($urandom_range(1, 16));
        3: a = BASE + 32'(NS * 65536) + 32'($urandom_range(0, 15));
        default: a = BASE + (32'($urandom_range(0, NS - 1)) << 16) + ($urandom_range(0, 1) ? 32'h0 : 32'hFFFC);
      endcase
      k = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO + 2));
      v = model(a, $urandom, 4'($urandom), k, $urandom);
      run_txn(v, 1'($urandom), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
